inst_rom_loader: RTL and testbench
==================================

Name: inst_rom_loader

Overview:
Responder side of the instruction-fetch interface: a word-addressed instruction memory that answers the core's fetch requests (ce, byte address) with a 32-bit instruction in the same cycle.
Memory contents are written at boot through a byte-stream load port (e.g. fed by a UART receiver). A state machine assembles bytes into big-endian words, writes them sequentially, and gates fetches until loading completes.
Sits between the core's fetch port and the boot-load source in the SoC top level.

Parameters:
ADDR_WIDTH, 10, log2 of memory depth in 32-bit words (DEPTH = 2**ADDR_WIDTH)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
ce_i  input  1  fetch enable from core
addr_i  input  32  fetch byte address from core
inst_o  output  32  fetched instruction, combinational
load_start_i  input  1  one-cycle pulse: begin (or restart) a load at word 0
load_valid_i  input  1  load byte valid
load_byte_i  input  8  load byte
load_last_i  input  1  qualifies the accepted byte as the final byte of the image
load_ready_o  output  1  loader accepts a byte this cycle
load_done_o  output  1  one-cycle pulse when loading finishes
busy_o  output  1  high while not in RUN
addr_err_o  output  1  sticky: RUN-state fetch hit an out-of-range address
load_ovf_o  output  1  sticky: image exceeded DEPTH words

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; wptr=0; byte_cnt=0; assembly register=0.
  - load_ready_o=0, load_done_o=0, addr_err_o=0, load_ovf_o=0, busy_o=1, inst_o=0.
  - Memory array is not reset.
- States:
  - IDLE: load_ready_o=0; start -> LOAD.
  - LOAD: load_ready_o=1.
  - RUN: load_ready_o=0; start -> LOAD.
  - Entering LOAD always clears wptr, byte_cnt and the assembly register.
- Byte acceptance: occurs when load_valid_i && load_ready_o.
  - Byte k (byte_cnt=k) fills bits [31-8k -: 8]; first byte lands in [31:24] (big-endian).
  - On the 4th byte (byte_cnt=3), the word {assembled[31:8], load_byte_i} is written to mem[wptr] at that same edge; wptr++, byte_cnt=0.
- load_last_i on an accepted byte:
  - The partial word is written with unfilled low bytes zero-padded.
  - Next state RUN; load_done_o=1 for exactly that following cycle.
- Overflow: a word write at wptr=DEPTH-1 without load_last_i goes to RUN, sets load_ovf_o, and pulses load_done_o. wptr never wraps.
- load_start_i while in LOAD restarts the load. Start has priority over a simultaneous valid byte; that byte is dropped.
- Fetch, combinational, no added latency:
  - inst_o = mem[addr_i[ADDR_WIDTH+1:2]] when state==RUN and ce_i=1 and addr_i[31:ADDR_WIDTH+2]==0.
  - Otherwise inst_o=0 (NOP).
  - addr_i[1:0] is ignored.
- addr_err_o is set on any clock edge where state==RUN, ce_i=1 and the address is out of range. It clears only on reset or on entering LOAD.
- Reset mid-load: aborts the load. Memory keeps any words already written; state returns to IDLE and fetches read 0.
- busy_o = (state != RUN).

Test Plan:
1. Reset, then ce_i=1, addr_i=0 -> inst_o=0, busy_o=1, load_ready_o=0.
2. Start pulse, then bytes 34,02,00,01 followed by 24,03,00,02 with last on the 8th byte:
   - load_done_o pulses one cycle later.
   - Fetching addr 0 gives 0x34020001; addr 4 gives 0x24030002; addr 6 also gives 0x24030002.
3. Start pulse, then bytes AA,BB with last on BB -> addr 0 reads 0xAABB0000 and load_done_o pulses.
4. ADDR_WIDTH=2, 17 bytes streamed without last:
   - load_ovf_o=1 after the 16th byte; the 17th byte is not accepted (load_ready_o=0).
   - addr 12 returns word 3.
5. In RUN, ce_i=1, addr_i=0x00001000 (ADDR_WIDTH=10):
   - inst_o=0; addr_err_o=1 next cycle and stays set.
   - A subsequent start pulse clears addr_err_o.
6. Drive start and a valid byte in the same LOAD cycle, then a reset mid-word:
   - The simultaneous byte is dropped and wptr=0.
   - The reset forces IDLE asynchronously; inst_o=0.

Source files
------------

// File: rtl/inst_rom_loader.sv
// Instruction memory with a boot-time byte-stream loader.
// Bytes arrive big-endian, are packed into 32-bit words and written one after
// another from word 0. Fetches return 0 (NOP) until the image has loaded.
//
// Load handshake: a byte moves on any rising edge where load_valid_i and
// load_ready_o are both high and load_start_i is low. load_ready_o is high for
// the whole LOAD state, and a start pulse in the same cycle wins and drops the
// byte.
module inst_rom_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    output logic [31:0] inst_o,
    input  logic        load_start_i,
    input  logic        load_valid_i,
    input  logic [7:0]  load_byte_i,
    input  logic        load_last_i,
    output logic        load_ready_o,
    output logic        load_done_o,
    output logic        busy_o,
    output logic        addr_err_o,
    output logic        load_ovf_o,
    output logic [1:0]  dbg_state_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [31:0]             asm_q, asm_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;
    logic                    err_q, err_d;

    logic [31:0]             mem_q [DEPTH];
    logic                    mem_we;
    logic [31:0]             merged;
    logic                    accept;

    // Word index of the fetch, and whether it lies inside the memory.
    logic [31:0]             word_addr;
    logic                    in_range;

    assign word_addr = addr_i >> 2;
    assign in_range  = (word_addr >> ADDR_WIDTH) == 32'd0;

    // Current partial word with the incoming byte dropped into its big-endian lane.
    always_comb begin
        merged = asm_q;
        case (byte_cnt_q)
            2'd0:    merged[31:24] = load_byte_i;
            2'd1:    merged[23:16] = load_byte_i;
            2'd2:    merged[15:8]  = load_byte_i;
            default: merged[7:0]   = load_byte_i;
        endcase
    end

    // Next-state logic: byte assembly, word writes, load termination and error flags.
    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        done_d       = 1'b0;
        ovf_d        = ovf_q;
        err_d        = err_q;
        mem_we       = 1'b0;
        load_ready_o = 1'b0;
        accept       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_start_i) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                load_ready_o = 1'b1;
                accept       = load_valid_i && !load_start_i;
                if (accept) begin
                    if (byte_cnt_q == 2'd3 || load_last_i) begin
                        // Unfilled low lanes of asm_q are still zero, so a short
                        // final word is zero-padded for free.
                        mem_we = 1'b1;
                        if (load_last_i) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else if (&wptr_q) begin
                            // Last word slot filled and more image to come: stop
                            // rather than wrap over word 0.
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                            ovf_d   = 1'b1;
                        end else begin
                            wptr_d     = wptr_q + ADDR_WIDTH'(1);
                            byte_cnt_d = 2'd0;
                            asm_d      = 32'd0;
                        end
                    end else begin
                        asm_d      = merged;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            ST_RUN: begin
                if (ce_i && !in_range) err_d = 1'b1;
                if (load_start_i) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

        // A start from any state (re)enters LOAD with a clean context.
        if (load_start_i) begin
            state_d    = ST_LOAD;
            wptr_d     = '0;
            byte_cnt_d = 2'd0;
            asm_d      = 32'd0;
            err_d      = 1'b0;
        end
    end

    // Control registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 32'd0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    // Instruction storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wptr_q] <= merged;
    end

    // Same-cycle fetch, NOP whenever the memory is not serving the core.
    always_comb begin
        inst_o = 32'd0;
        if (state_q == ST_RUN && ce_i && in_range)
            inst_o = mem_q[word_addr[ADDR_WIDTH-1:0]];
    end

    assign load_done_o = done_q;
    assign busy_o      = (state_q != ST_RUN);
    assign addr_err_o  = err_q;
    assign load_ovf_o  = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: directed boot-load scenarios plus random images
// checked against a word-level model of the loaded memory.
module tb_inst_rom_loader;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // main instance (1024 words)
    logic        ce, start, valid, last_v;
    logic [31:0] addr, inst;
    logic [7:0]  byte_v;
    logic        ready, done, busy, err, ovf;
    logic [1:0]  dbg;

    // small instance (4 words) for overflow
    logic        s_ce, s_start, s_valid, s_last;
    logic [31:0] s_addr, s_inst;
    logic [7:0]  s_byte;
    logic        s_ready, s_done, s_busy, s_err, s_ovf;
    logic [1:0]  s_dbg;

    inst_rom_loader #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .ce_i(ce), .addr_i(addr), .inst_o(inst),
        .load_start_i(start), .load_valid_i(valid), .load_byte_i(byte_v),
        .load_last_i(last_v), .load_ready_o(ready), .load_done_o(done),
        .busy_o(busy), .addr_err_o(err), .load_ovf_o(ovf), .dbg_state_o(dbg)
    );

    inst_rom_loader #(.ADDR_WIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .ce_i(s_ce), .addr_i(s_addr), .inst_o(s_inst),
        .load_start_i(s_start), .load_valid_i(s_valid), .load_byte_i(s_byte),
        .load_last_i(s_last), .load_ready_o(s_ready), .load_done_o(s_done),
        .busy_o(s_busy), .addr_err_o(s_err), .load_ovf_o(s_ovf), .dbg_state_o(s_dbg)
    );

    // ---------------- scoreboard / model ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  img_q[$];
    logic [31:0] model_mem [1024];
    int          max_w = 0;
    logic        exp_err = 1'b0;
    logic [7:0]  sb [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Word w of the current image, big-endian, zero beyond the last byte.
    function automatic logic [31:0] pack_word(input int w);
        logic [31:0] r = 32'd0;
        for (int j = 0; j < 4; j++)
            if (4 * w + j < img_q.size()) r[31 - 8 * j -: 8] = img_q[4 * w + j];
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        valid  = 1'b1;
        byte_v = b;
        last_v = l;
        #1;
        check("load_ready", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        valid  = 1'b0;
        last_v = 1'b0;
    endtask

    task automatic load_image(input logic with_last);
        int nw;
        for (int i = 0; i < img_q.size(); i++)
            send_byte(img_q[i], with_last && (i == img_q.size() - 1));
        nw = (img_q.size() + 3) / 4;
        for (int w = 0; w < nw; w++) model_mem[w] = pack_word(w);
        if (nw > max_w) max_w = nw;
    endtask

    task automatic fetch_check(input logic [31:0] a, input logic ce_v);
        logic oor;
        oor  = (a >= 32'h0000_1000);
        ce   = ce_v;
        addr = a;
        #1;
        exp_q.push_back((ce_v && !oor) ? model_mem[a >> 2] : 32'd0);
        check("fetch", inst, exp_q.pop_front());
        if (ce_v && oor) exp_err = 1'b1;
        tick();
        check("addr_err", {31'd0, err}, {31'd0, exp_err});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        ce = 1'b1; addr = 32'd0; start = 1'b0; valid = 1'b0; byte_v = 8'd0; last_v = 1'b0;
        s_ce = 1'b0; s_addr = 32'd0; s_start = 1'b0; s_valid = 1'b0; s_byte = 8'd0; s_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        check("rst_inst", inst, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_s_busy", {31'd0, s_busy}, 32'd1);
        #2 rst = 1'b1;
        tick();
        check("idle_inst", inst, 32'd0);
        check("idle_ready", {31'd0, ready}, 32'd0);

        // two-word image
        pulse_start();
        check("load_busy", {31'd0, busy}, 32'd1);
        check("load_ready_idle", {31'd0, ready}, 32'd1);
        img_q = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h24, 8'h03, 8'h00, 8'h02};
        load_image(1'b1);
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_busy", {31'd0, busy}, 32'd0);
        check("t2_ready", {31'd0, ready}, 32'd0);
        tick();
        check("t2_done_clr", {31'd0, done}, 32'd0);
        fetch_check(32'd0, 1'b1);
        fetch_check(32'd4, 1'b1);
        fetch_check(32'd6, 1'b1);
        ce = 1'b1; addr = 32'd4; #1;
        check("t2_const", inst, 32'h2403_0002);
        fetch_check(32'd0, 1'b0);

        // partial final word
        pulse_start();
        img_q = '{8'hAA, 8'hBB};
        load_image(1'b1);
        check("t3_done", {31'd0, done}, 32'd1);
        ce = 1'b1; addr = 32'd0; #1;
        check("t3_const", inst, 32'hAABB_0000);
        tick();
        fetch_check(32'd0, 1'b1);
        fetch_check(32'd4, 1'b1);

        // out-of-range fetch
        ce = 1'b1; addr = 32'h0000_1000; #1;
        check("t5_inst", inst, 32'd0);
        check("t5_err_pre", {31'd0, err}, 32'd0);
        tick();
        check("t5_err", {31'd0, err}, 32'd1);
        addr = 32'd0; #1;
        check("t5_inst_ok", inst, 32'hAABB_0000);
        tick();
        check("t5_err_sticky", {31'd0, err}, 32'd1);
        pulse_start();
        check("t5_err_clr", {31'd0, err}, 32'd0);

        // start colliding with a byte, then restart from word 0
        start = 1'b1; valid = 1'b1; byte_v = 8'h11;
        tick();
        start = 1'b0; valid = 1'b0;
        img_q = '{8'h55, 8'h66, 8'h77, 8'h88};
        load_image(1'b1);
        ce = 1'b1; addr = 32'd0; #1;
        check("t6_drop", inst, 32'h5566_7788);
        tick();
        fetch_check(32'd4, 1'b1);

        // reset in the middle of a word
        pulse_start();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_busy", {31'd0, busy}, 32'd1);
        check("t6_rst_ready", {31'd0, ready}, 32'd0);
        check("t6_rst_inst", inst, 32'd0);
        #3 rst = 1'b1;
        tick();
        pulse_start();
        img_q = '{8'h99};
        load_image(1'b1);
        tick();
        fetch_check(32'd0, 1'b1);
        fetch_check(32'd4, 1'b1);

        // random images and random fetches
        for (int it = 0; it < 6; it++) begin
            int n;
            pulse_start();
            check("rnd_err_clr", {31'd0, err}, 32'd0);
            n = $urandom_range(1, 48);
            img_q = {};
            for (int i = 0; i < n; i++) img_q.push_back(8'($urandom_range(0, 255)));
            load_image(1'b1);
            check("rnd_done", {31'd0, done}, 32'd1);
            check("rnd_busy", {31'd0, busy}, 32'd0);
            tick();
            for (int k = 0; k < 10; k++) begin
                int unsigned kind;
                logic [31:0] a;
                kind = $urandom_range(0, 5);
                if (kind == 0) begin
                    a = $urandom;
                    if (a < 32'h0000_1000) a = a | 32'h0000_1000;
                    fetch_check(a, 1'b1);
                end else if (kind == 1) begin
                    fetch_check($urandom, 1'b0);
                end else begin
                    fetch_check($urandom_range(0, 4 * max_w - 1), 1'b1);
                end
            end
        end

        // overflow on a 4-word memory
        s_start = 1'b1; tick(); s_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sb[i]   = 8'($urandom_range(0, 255));
            s_valid = 1'b1;
            s_byte  = sb[i];
            #1;
            check("s_ready", {31'd0, s_ready}, 32'd1);
            tick();
            if (i == 14) check("s_ovf_pre", {31'd0, s_ovf}, 32'd0);
        end
        check("s_ovf", {31'd0, s_ovf}, 32'd1);
        check("s_done", {31'd0, s_done}, 32'd1);
        check("s_busy", {31'd0, s_busy}, 32'd0);
        s_valid = 1'b1; s_byte = 8'hEE; #1;
        check("s_ready_17", {31'd0, s_ready}, 32'd0);
        tick();
        s_valid = 1'b0;
        check("s_done_clr", {31'd0, s_done}, 32'd0);
        check("s_ovf_sticky", {31'd0, s_ovf}, 32'd1);
        s_ce = 1'b1; s_addr = 32'd12; #1;
        check("s_word3", s_inst, {sb[12], sb[13], sb[14], sb[15]});
        s_addr = 32'd1; #1;
        check("s_word0", s_inst, {sb[0], sb[1], sb[2], sb[3]});
        s_addr = 32'd16; #1;
        check("s_oor_inst", s_inst, 32'd0);
        tick();
        check("s_oor_err", {31'd0, s_err}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
